// File: rtl/i2cmb_byte_engine.sv
// ---------------------------------------------------------------------------
// i2cmb_byte_engine
//
// Byte-level command engine of the I2C multiple-bus master. Accepts one
// byte command at a time (START, STOP, WRITE, READ_ACK/NAK, SET_BUS, WAIT)
// from the register block and expands it into handshaked bit operations for
// the bit-level sequencer. Tracks bus ownership and returns one response
// code per command.
//
// Ports
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake (ready only in IDLE)
//   cmd_code_i[2:0]      command code
//   cmd_data_i[7:0]      write byte / bus id / millisecond count
//   rsp_valid_o          one-cycle response strobe
//   rsp_code_o[1:0]      DONE / NAK / ARB_LOST / ERROR, held
//   rx_data_o[7:0]       byte from the last completed READ, held
//   bus_id_o             selected bus
//   bit_req_o            bit-operation request, held until bit_ack_i
//   bit_op_o[1:0]        START / STOP / WRITE / READ
//   bit_wdata_o          bit value for a WRITE bit operation
//   bit_ack_i            completion of the current bit operation
//   bit_rdata_i          sampled SDA, valid with bit_ack_i
//   bit_arb_lost_i       arbitration lost, valid with bit_ack_i
//   ms_tick_i            one pulse per millisecond
// ---------------------------------------------------------------------------
module i2cmb_byte_engine #(
    parameter int unsigned NUM_BUSSES = 16,
    parameter int unsigned BUS_ID_W   = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_code_i,
    input  logic [7:0]          cmd_data_i,
    output logic                rsp_valid_o,
    output logic [1:0]          rsp_code_o,
    output logic [7:0]          rx_data_o,
    output logic [BUS_ID_W-1:0] bus_id_o,
    output logic                bit_req_o,
    output logic [1:0]          bit_op_o,
    output logic                bit_wdata_o,
    input  logic                bit_ack_i,
    input  logic                bit_rdata_i,
    input  logic                bit_arb_lost_i,
    input  logic                ms_tick_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STOP, S_WR_BIT, S_WR_ACK, S_RD_BIT, S_RD_ACK, S_WAIT
    } state_e;

    typedef enum logic [2:0] {
        C_START, C_STOP, C_READ_ACK, C_READ_NAK, C_WRITE, C_SET_BUS, C_WAIT, C_RSVD
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_DONE, RSP_NAK, RSP_ARB_LOST, RSP_ERROR
    } rsp_e;

    typedef enum logic [1:0] {
        OP_START, OP_STOP, OP_WRITE, OP_READ
    } bitop_e;

    localparam logic [8:0] LP_NUM_BUSSES = 9'(NUM_BUSSES);

    // Registers
    state_e              r_state;
    logic                r_bit_req;
    logic [2:0]          r_cnt;
    logic [7:0]          r_shift;
    logic                r_nak;
    logic [7:0]          r_wait;
    logic                r_captured;
    logic                r_rsp_valid;
    rsp_e                r_rsp_code;
    logic [7:0]          r_rx;
    logic [BUS_ID_W-1:0] r_bus_id;

    // Next-state values
    state_e              w_state_nxt;
    logic                w_bit_req_nxt;
    logic [2:0]          w_cnt_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_nak_nxt;
    logic [7:0]          w_wait_nxt;
    logic                w_captured_nxt;
    logic                w_rsp_valid_nxt;
    rsp_e                w_rsp_code_nxt;
    logic [7:0]          w_rx_nxt;
    logic [BUS_ID_W-1:0] w_bus_id_nxt;

    logic   w_accept;
    logic   w_ack;
    logic   w_err;
    cmd_e   w_cmd;
    bitop_e w_bit_op;
    logic   w_bit_wdata;

    assign w_cmd    = cmd_e'(cmd_code_i);
    assign w_accept = cmd_valid_i && (r_state == S_IDLE);
    // An ack is only meaningful while a request is outstanding.
    assign w_ack    = bit_ack_i && r_bit_req;

    always_comb begin
        w_err = 1'b0;
        unique case (w_cmd)
            C_STOP, C_READ_ACK, C_READ_NAK, C_WRITE: w_err = !r_captured;
            C_SET_BUS: w_err = r_captured || ({1'b0, cmd_data_i} >= LP_NUM_BUSSES);
            C_WAIT:    w_err = r_captured;
            C_RSVD:    w_err = 1'b1;
            C_START:   w_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_bit_req   <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_nak       <= 1'b0;
            r_wait      <= '0;
            r_captured  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_code  <= RSP_DONE;
            r_rx        <= '0;
            r_bus_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_req   <= w_bit_req_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_nak       <= w_nak_nxt;
            r_wait      <= w_wait_nxt;
            r_captured  <= w_captured_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_code  <= w_rsp_code_nxt;
            r_rx        <= w_rx_nxt;
            r_bus_id    <= w_bus_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_req_nxt   = r_bit_req;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_nak_nxt       = r_nak;
        w_wait_nxt      = r_wait;
        w_captured_nxt  = r_captured;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_code_nxt  = r_rsp_code;
        w_rx_nxt        = r_rx;
        w_bus_id_nxt    = r_bus_id;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_code_nxt  = RSP_ERROR;
                    end else begin
                        unique case (w_cmd)
                            C_START: begin
                                w_state_nxt   = S_START;
                                w_bit_req_nxt = 1'b1;
                            end
                            C_STOP: begin
                                w_state_nxt   = S_STOP;
                                w_bit_req_nxt = 1'b1;
                            end
                            C_WRITE: begin
                                w_state_nxt   = S_WR_BIT;
                                w_bit_req_nxt = 1'b1;
                                w_shift_nxt   = cmd_data_i;
                                w_cnt_nxt     = '0;
                            end
                            C_READ_ACK, C_READ_NAK: begin
                                w_state_nxt   = S_RD_BIT;
                                w_bit_req_nxt = 1'b1;
                                w_nak_nxt     = cmd_code_i[0];
                                w_cnt_nxt     = '0;
                            end
                            C_SET_BUS: begin
                                w_bus_id_nxt    = cmd_data_i[BUS_ID_W-1:0];
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_code_nxt  = RSP_DONE;
                            end
                            C_WAIT: begin
                                if (cmd_data_i == 8'd0) begin
                                    w_rsp_valid_nxt = 1'b1;
                                    w_rsp_code_nxt  = RSP_DONE;
                                end else begin
                                    w_state_nxt = S_WAIT;
                                    w_wait_nxt  = cmd_data_i;
                                end
                            end
                            C_RSVD: ;
                        endcase
                    end
                end
            end

            S_WAIT: begin
                if (ms_tick_i) begin
                    w_wait_nxt = r_wait - 8'd1;
                    if (r_wait == 8'd1) begin
                        w_state_nxt     = S_IDLE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_code_nxt  = RSP_DONE;
                    end
                end
            end

            default: begin
                // Bit-operation states: a low request here is the one-cycle
                // gap after the previous ack, so re-raise it.
                if (!r_bit_req) begin
                    w_bit_req_nxt = 1'b1;
                end else if (w_ack) begin
                    w_bit_req_nxt = 1'b0;
                    if (bit_arb_lost_i) begin
                        w_state_nxt     = S_IDLE;
                        w_captured_nxt  = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_code_nxt  = RSP_ARB_LOST;
                    end else begin
                        unique case (r_state)
                            S_START: begin
                                w_state_nxt     = S_IDLE;
                                w_captured_nxt  = 1'b1;
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_code_nxt  = RSP_DONE;
                            end
                            S_STOP: begin
                                w_state_nxt     = S_IDLE;
                                w_captured_nxt  = 1'b0;
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_code_nxt  = RSP_DONE;
                            end
                            S_WR_BIT: begin
                                w_shift_nxt = {r_shift[6:0], 1'b0};
                                w_cnt_nxt   = r_cnt + 3'd1;
                                if (r_cnt == 3'd7) w_state_nxt = S_WR_ACK;
                            end
                            S_WR_ACK: begin
                                w_state_nxt     = S_IDLE;
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_code_nxt  = bit_rdata_i ? RSP_NAK : RSP_DONE;
                            end
                            S_RD_BIT: begin
                                w_shift_nxt = {r_shift[6:0], bit_rdata_i};
                                w_cnt_nxt   = r_cnt + 3'd1;
                                if (r_cnt == 3'd7) w_state_nxt = S_RD_ACK;
                            end
                            S_RD_ACK: begin
                                w_state_nxt     = S_IDLE;
                                w_rx_nxt        = r_shift;
                                w_rsp_valid_nxt = 1'b1;
                                w_rsp_code_nxt  = RSP_DONE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    // Operation and data are decoded from state; both only change on the
    // ack edge, so they are stable for the whole request.
    always_comb begin
        w_bit_op    = OP_START;
        w_bit_wdata = 1'b0;
        unique case (r_state)
            S_START:  w_bit_op = OP_START;
            S_STOP:   w_bit_op = OP_STOP;
            S_WR_BIT: begin
                w_bit_op    = OP_WRITE;
                w_bit_wdata = r_shift[7];
            end
            S_WR_ACK: w_bit_op = OP_READ;
            S_RD_BIT: w_bit_op = OP_READ;
            S_RD_ACK: begin
                w_bit_op    = OP_WRITE;
                w_bit_wdata = r_nak;
            end
            default:  ;
        endcase
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_code_o  = r_rsp_code;
    assign rx_data_o   = r_rx;
    assign bus_id_o    = r_bus_id;
    assign bit_req_o   = r_bit_req;
    assign bit_op_o    = w_bit_op;
    assign bit_wdata_o = w_bit_wdata;

endmodule

// File: tb/tb_i2cmb_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_i2cmb_byte_engine
//
// Directed testbench for i2cmb_byte_engine. Plays the role of the bit-level
// sequencer (acks each request after three cycles, returns scripted read
// bits, optionally flags arbitration loss) and checks responses, bit
// sequences and handshake timing against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2cmb_byte_engine;

    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_RD_ACK = 3'd2, C_RD_NAK = 3'd3,
                           C_WRITE = 3'd4, C_SETBUS = 3'd5, C_WAIT = 3'd6, C_RSVD = 3'd7;
    localparam logic [1:0] R_DONE = 2'd0, R_NAK = 2'd1, R_ARB = 2'd2, R_ERR = 2'd3;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [2:0] cmd_code_i = '0;
    logic [7:0] cmd_data_i = '0;
    logic       rsp_valid_o;
    logic [1:0] rsp_code_o;
    logic [7:0] rx_data_o;
    logic [3:0] bus_id_o;
    logic       bit_req_o;
    logic [1:0] bit_op_o;
    logic       bit_wdata_o;
    logic       bit_ack_i = 1'b0;
    logic       bit_rdata_i = 1'b0;
    logic       bit_arb_lost_i = 1'b0;
    logic       ms_tick_i = 1'b0;

    always #5 clk_i = ~clk_i;

    i2cmb_byte_engine #(.NUM_BUSSES(16), .BUS_ID_W(4)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_code_i     (cmd_code_i),
        .cmd_data_i     (cmd_data_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_code_o     (rsp_code_o),
        .rx_data_o      (rx_data_o),
        .bus_id_o       (bus_id_o),
        .bit_req_o      (bit_req_o),
        .bit_op_o       (bit_op_o),
        .bit_wdata_o    (bit_wdata_o),
        .bit_ack_i      (bit_ack_i),
        .bit_rdata_i    (bit_rdata_i),
        .bit_arb_lost_i (bit_arb_lost_i),
        .ms_tick_i      (ms_tick_i)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] op_log [0:15];
    logic       wd_log [0:15];
    int         s_nops;
    int         s_lat;
    logic [1:0] s_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [2:0] code, input logic [7:0] data);
        check("cmd_ready", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1;
        cmd_code_i  = code;
        cmd_data_i  = data;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Bit-sequencer model: ack every request on its third high cycle.
    // Op i returns rseq[8-i]; arbitration loss is flagged on op arb_at.
    // Returns at the response cycle without advancing past it.
    task automatic serve(input logic [8:0] rseq, input int arb_at);
        int         hi, lowrun, ack_c;
        logic [1:0] cur_op;
        logic       cur_wd;
        bit         done;
        hi = 0; lowrun = 0; ack_c = 0; done = 0; cur_op = '0; cur_wd = 1'b0;
        s_nops = 0; s_lat = -1; s_rsp = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            bit_ack_i = 1'b0; bit_arb_lost_i = 1'b0; bit_rdata_i = 1'b0;
            if (rsp_valid_o) begin
                done  = 1;
                s_rsp = rsp_code_o;
                s_lat = (s_nops > 0) ? c - ack_c : c;
                check("req_at_rsp", 32'(bit_req_o), 0);
            end else begin
                if (bit_req_o) begin
                    if (hi == 0) begin
                        check("req_gap", 32'(lowrun), (s_nops == 0) ? 0 : 1);
                        cur_op = bit_op_o;
                        cur_wd = bit_wdata_o;
                        if (s_nops < 16) begin
                            op_log[s_nops] = bit_op_o;
                            wd_log[s_nops] = bit_wdata_o;
                        end
                    end else begin
                        check("op_stable", 32'({bit_op_o, bit_wdata_o}), 32'({cur_op, cur_wd}));
                    end
                    hi++;
                    if (hi == 3) begin
                        bit_ack_i      = 1'b1;
                        bit_rdata_i    = (s_nops < 9) ? rseq[8 - s_nops] : 1'b0;
                        bit_arb_lost_i = (s_nops == arb_at);
                        hi     = 0;
                        lowrun = 0;
                        ack_c  = c;
                        s_nops++;
                    end
                end else begin
                    lowrun++;
                end
                step();
            end
        end
        bit_ack_i = 1'b0; bit_arb_lost_i = 1'b0; bit_rdata_i = 1'b0;
        if (!done) check("rsp_timeout", 0, 1);
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] code, input logic [7:0] data,
                          input logic [8:0] rseq, input int arb_at,
                          input logic [1:0] exp_rsp, input int exp_nops);
        issue(code, data);
        serve(rseq, arb_at);
        check($sformatf("%s.rsp", tag), 32'(s_rsp), 32'(exp_rsp));
        check($sformatf("%s.nops", tag), 32'(s_nops), 32'(exp_nops));
        check($sformatf("%s.lat", tag), 32'(s_lat), (exp_nops > 0) ? 1 : 0);
    endtask

    function automatic logic [7:0] wr_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = wd_log[i];
        return b;
    endfunction

    initial begin
        logic [1:0] ops_or;
        int         req_seen;

        // Reset values
        rst_n_i = 1'b0;
        repeat (3) step();
        check("rst.ready",  32'(cmd_ready_o), 1);
        check("rst.rspv",   32'(rsp_valid_o), 0);
        check("rst.rspc",   32'(rsp_code_o), 0);
        check("rst.rx",     32'(rx_data_o), 0);
        check("rst.bus",    32'(bus_id_o), 0);
        check("rst.req",    32'(bit_req_o), 0);
        check("rst.op",     32'(bit_op_o), 0);
        check("rst.wd",     32'(bit_wdata_o), 0);
        rst_n_i = 1'b1;
        step();

        // Illegal before ownership, out-of-range bus, reserved code
        do_cmd("wr_nocap",  C_WRITE,  8'h55, 9'h000, -1, R_ERR, 0);
        do_cmd("rd_nocap",  C_RD_ACK, 8'h00, 9'h000, -1, R_ERR, 0);
        do_cmd("stop_nocap",C_STOP,   8'h00, 9'h000, -1, R_ERR, 0);
        do_cmd("setbus16",  C_SETBUS, 8'd16, 9'h000, -1, R_ERR, 0);
        check("bus_after16", 32'(bus_id_o), 0);
        do_cmd("rsvd",      C_RSVD,   8'h00, 9'h000, -1, R_ERR, 0);

        // SET_BUS 3, START, WRITE 0xA5 (ACK), STOP -- back to back
        do_cmd("setbus3", C_SETBUS, 8'd3, 9'h000, -1, R_DONE, 0);
        check("bus_id", 32'(bus_id_o), 3);
        do_cmd("start", C_START, 8'h00, 9'h000, -1, R_DONE, 1);
        check("start.op", 32'(op_log[0]), 0);
        do_cmd("wrA5", C_WRITE, 8'hA5, 9'h000, -1, R_DONE, 9);
        check("wrA5.bits", 32'(wr_byte()), 'hA5);
        ops_or = '0;
        for (int i = 0; i < 8; i++) ops_or |= (op_log[i] ^ 2'b10);
        check("wrA5.ops", 32'(ops_or), 0);
        check("wrA5.ackop", 32'(op_log[8]), 3);
        do_cmd("stop", C_STOP, 8'h00, 9'h000, -1, R_DONE, 1);
        check("stop.op", 32'(op_log[0]), 1);
        step();
        check("rsp_pulse", 32'(rsp_valid_o), 0);

        // START, READ_NAK 0x3C, READ_ACK 0x96, STOP
        do_cmd("start2", C_START, 8'h00, 9'h000, -1, R_DONE, 1);
        do_cmd("rdnak", C_RD_NAK, 8'h00, {8'h3C, 1'b0}, -1, R_DONE, 9);
        check("rdnak.rx", 32'(rx_data_o), 'h3C);
        check("rdnak.op0", 32'(op_log[0]), 3);
        check("rdnak.op7", 32'(op_log[7]), 3);
        check("rdnak.ackop", 32'(op_log[8]), 2);
        check("rdnak.ackwd", 32'(wd_log[8]), 1);
        do_cmd("rdack", C_RD_ACK, 8'h00, {8'h96, 1'b0}, -1, R_DONE, 9);
        check("rdack.rx", 32'(rx_data_o), 'h96);
        check("rdack.ackop", 32'(op_log[8]), 2);
        check("rdack.ackwd", 32'(wd_log[8]), 0);

        // A stray ack while no request is pending must be ignored
        step();
        bit_ack_i = 1'b1; bit_arb_lost_i = 1'b1;
        step();
        bit_ack_i = 1'b0; bit_arb_lost_i = 1'b0;
        check("stray_ack.rspv", 32'(rsp_valid_o), 0);

        // WRITE with NAK keeps ownership; captured-state errors
        do_cmd("wrnak", C_WRITE, 8'h81, 9'h001, -1, R_NAK, 9);
        check("wr81.bits", 32'(wr_byte()), 'h81);
        do_cmd("setbus_cap", C_SETBUS, 8'd5, 9'h000, -1, R_ERR, 0);
        check("bus_kept", 32'(bus_id_o), 3);
        do_cmd("wait_cap", C_WAIT, 8'd2, 9'h000, -1, R_ERR, 0);

        // Repeated start, then arbitration loss on bit 4 of a WRITE
        do_cmd("rstart", C_START, 8'h00, 9'h000, -1, R_DONE, 1);
        do_cmd("wr_arb", C_WRITE, 8'hF0, 9'h000, 4, R_ARB, 5);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bit_req_o) req_seen++;
        end
        check("arb.noreq", 32'(req_seen), 0);
        check("arb.rx_kept", 32'(rx_data_o), 'h96);
        do_cmd("wr_after_arb", C_WRITE, 8'h12, 9'h000, -1, R_ERR, 0);

        // WAIT 3: tick on acceptance is ignored, then ticks 5 cycles apart
        check("wait.ready", 32'(cmd_ready_o), 1);
        cmd_valid_i = 1'b1; cmd_code_i = C_WAIT; cmd_data_i = 8'd3; ms_tick_i = 1'b1;
        step();
        cmd_valid_i = 1'b0; ms_tick_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (4) step();
            check($sformatf("wait.early%0d", k), 32'(rsp_valid_o), 0);
            ms_tick_i = 1'b1;
            step();
            ms_tick_i = 1'b0;
        end
        check("wait3.rspv", 32'(rsp_valid_o), 1);
        check("wait3.rspc", 32'(rsp_code_o), 32'(R_DONE));
        do_cmd("wait0", C_WAIT, 8'd0, 9'h000, -1, R_DONE, 0);

        // Reset in the middle of a READ
        do_cmd("start3", C_START, 8'h00, 9'h000, -1, R_DONE, 1);
        issue(C_RD_ACK, 8'h00);
        step();
        check("mid.req", 32'(bit_req_o), 1);
        rst_n_i = 1'b0;
        #1;
        check("mid.req_drop", 32'(bit_req_o), 0);
        check("mid.op", 32'(bit_op_o), 0);
        check("mid.rx", 32'(rx_data_o), 0);
        check("mid.bus", 32'(bus_id_o), 0);
        step();
        rst_n_i = 1'b1;
        step();
        check("post.ready", 32'(cmd_ready_o), 1);
        check("post.rspv", 32'(rsp_valid_o), 0);
        do_cmd("post.wr", C_WRITE, 8'h33, 9'h000, -1, R_ERR, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
